// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - RV32I IF stage: fetch PC, single-outstanding imem requests, IF/ID register
// Redirects during an in-flight fetch mark it killed so its response never reaches IF/ID.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pc_jump,
    input  logic [31:0] pc_jump_addr,
    input  logic        flush,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_instr,
    output logic        if_id_valid
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        kill_q, kill_d;
    logic [31:0] skid_instr_q;
    logic        skid_load;
    logic        ifid_load;
    logic [31:0] ifid_instr_d;
    logic        req_q;
    logic [31:0] addr_q;
    logic [31:0] ifid_pc_q, ifid_instr_q;
    logic        ifid_valid_q;

    // The skid entry's PC is pc_q itself: pc only moves when HOLD is left.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        kill_d       = kill_q;
        skid_load    = 1'b0;
        ifid_load    = 1'b0;
        ifid_instr_d = imem_rdata;
        case (state_q)
            IDLE: state_d = REQ;
            REQ: begin
                if (imem_gnt) begin
                    state_d = WAIT;
                    kill_d  = pc_jump;
                end
                if (pc_jump) pc_d = pc_jump_addr;
            end
            WAIT: begin
                if (imem_rvalid) begin
                    if (kill_q || pc_jump) begin
                        kill_d  = 1'b0;
                        state_d = REQ;
                        if (pc_jump) pc_d = pc_jump_addr;
                    end else if (stall) begin
                        skid_load = 1'b1;
                        state_d   = HOLD;
                    end else begin
                        ifid_load = 1'b1;
                        pc_d      = pc_q + 32'd4;
                        state_d   = REQ;
                    end
                end else if (pc_jump) begin
                    pc_d   = pc_jump_addr;
                    kill_d = 1'b1;
                end
            end
            HOLD: begin
                if (pc_jump) begin
                    pc_d    = pc_jump_addr;
                    state_d = REQ;
                end else if (!stall) begin
                    ifid_load    = 1'b1;
                    ifid_instr_d = skid_instr_q;
                    pc_d         = pc_q + 32'd4;
                    state_d      = REQ;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            pc_q         <= RESET_PC;
            kill_q       <= 1'b0;
            skid_instr_q <= NOP_INSTR;
            req_q        <= 1'b0;
            addr_q       <= RESET_PC;
            ifid_pc_q    <= 32'h0;
            ifid_instr_q <= NOP_INSTR;
            ifid_valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            kill_q  <= kill_d;
            // Request outputs are precomputed from next state so they leave a flop.
            req_q   <= (state_d == REQ);
            addr_q  <= pc_d;
            if (skid_load) skid_instr_q <= imem_rdata;
            if (flush) begin
                ifid_valid_q <= 1'b0;
                ifid_instr_q <= NOP_INSTR;
            end else if (stall) begin
                ifid_valid_q <= ifid_valid_q;
            end else if (ifid_load) begin
                ifid_pc_q    <= pc_q;
                ifid_instr_q <= ifid_instr_d;
                ifid_valid_q <= 1'b1;
            end else begin
                ifid_valid_q <= 1'b0;
            end
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = addr_q;
    assign if_id_pc    = ifid_pc_q;
    assign if_id_instr = ifid_instr_q;
    assign if_id_valid = ifid_valid_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb/tb_if_fetch_unit.sv - scoreboard bench for if_fetch_unit
module tb_if_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pc_jump = 1'b0;
    logic [31:0] pc_jump_addr = 32'h0;
    logic        flush = 1'b0;
    logic        stall = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_instr;
    logic        if_id_valid;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] exp_addr_q[$];
    logic [63:0] exp_ifid_q[$];
    logic [31:0] mon_addr;
    logic [63:0] mon_ifid;
    logic        rec_stall = 1'b1;
    logic        rec_flush = 1'b0;
    logic        rec_rst = 1'b1;

    if_fetch_unit dut (
        .clk          (clk),
        .rst          (rst),
        .pc_jump      (pc_jump),
        .pc_jump_addr (pc_jump_addr),
        .flush        (flush),
        .stall        (stall),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_gnt     (imem_gnt),
        .imem_rvalid  (imem_rvalid),
        .imem_rdata   (imem_rdata),
        .if_id_pc     (if_id_pc),
        .if_id_instr  (if_id_instr),
        .if_id_valid  (if_id_valid)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Assumes the DUT is currently presenting a request for address a.
    task automatic fetch(input logic [31:0] a, input logic [31:0] d, input int gdly);
        logic [31:0] nxt;
        nxt = a + 32'd4;
        for (int i = 0; i < gdly; i++) begin
            chk("req_held", {31'h0, imem_req}, 32'h1);
            chk("addr_stable", imem_addr, a);
            tick();
        end
        exp_addr_q.push_back(a);
        imem_gnt = 1'b1;
        tick();
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = d;
        exp_ifid_q.push_back({a, d});
        tick();
        imem_rvalid = 1'b0;
        chk("next_req", {31'h0, imem_req}, 32'h1);
        chk("next_addr", imem_addr, nxt);
    endtask

    // Monitor: handshakes and fresh IF/ID loads are popped against the scoreboard queues.
    always @(negedge clk) begin
        if (imem_req && imem_gnt) begin
            if (exp_addr_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL handshake: got unexpected addr %h expected none", imem_addr);
            end else begin
                mon_addr = exp_addr_q.pop_front();
                chk("handshake_addr", imem_addr, mon_addr);
            end
        end
        if (if_id_valid && !rec_stall && !rec_flush && !rec_rst) begin
            if (exp_ifid_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL ifid_load: got unexpected pc %h instr %h expected none", if_id_pc, if_id_instr);
            end else begin
                mon_ifid = exp_ifid_q.pop_front();
                chk("ifid_pc", if_id_pc, mon_ifid[63:32]);
                chk("ifid_instr", if_id_instr, mon_ifid[31:0]);
            end
        end
        rec_stall = stall;
        rec_flush = flush;
        rec_rst   = rst;
    end

    initial begin
        // Reset state
        repeat (3) tick();
        chk("rst_req", {31'h0, imem_req}, 32'h0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_valid", {31'h0, if_id_valid}, 32'h0);
        chk("rst_instr", if_id_instr, 32'h0000_0013);
        chk("rst_pc", if_id_pc, 32'h0);

        // 1: first fetch, IF/ID valid on the third edge after release
        rst = 1'b0;
        tick();
        chk("t1_req", {31'h0, imem_req}, 32'h1);
        chk("t1_addr", imem_addr, 32'h0);
        fetch(32'h0, 32'h0050_0093, 0);
        chk("t1_valid", {31'h0, if_id_valid}, 32'h1);
        chk("t1_instr", if_id_instr, 32'h0050_0093);

        // 2: grant withheld for 4 cycles
        fetch(32'h4, 32'h0010_0113, 4);

        // 3: redirect in the grant cycle discards the 0x8 response
        exp_addr_q.push_back(32'h8);
        imem_gnt = 1'b1; pc_jump = 1'b1; pc_jump_addr = 32'h100; flush = 1'b1;
        tick();
        imem_gnt = 1'b0; pc_jump = 1'b0; flush = 1'b0;
        chk("t3_flush_valid", {31'h0, if_id_valid}, 32'h0);
        chk("t3_wait_req", {31'h0, imem_req}, 32'h0);
        imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        tick();
        imem_rvalid = 1'b0;
        chk("t3_valid", {31'h0, if_id_valid}, 32'h0);
        chk("t3_req", {31'h0, imem_req}, 32'h1);
        chk("t3_addr", imem_addr, 32'h100);
        fetch(32'h100, 32'h0020_8093, 0);

        // Ungranted request retargeted by a redirect
        pc_jump = 1'b1; pc_jump_addr = 32'h8; flush = 1'b1;
        tick();
        pc_jump = 1'b0; flush = 1'b0;
        chk("retarget_req", {31'h0, imem_req}, 32'h1);
        chk("retarget_addr", imem_addr, 32'h8);
        fetch(32'h8, 32'h0030_8193, 1);

        // 4: stall for 3 cycles around the 0xC response
        exp_addr_q.push_back(32'hC);
        imem_gnt = 1'b1; stall = 1'b1;
        tick();
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h00A0_0113;
        chk("t4_hold_valid0", {31'h0, if_id_valid}, 32'h1);
        chk("t4_hold_pc0", if_id_pc, 32'h8);
        tick();
        imem_rvalid = 1'b0;
        chk("t4_hold_valid1", {31'h0, if_id_valid}, 32'h1);
        chk("t4_hold_req1", {31'h0, imem_req}, 32'h0);
        tick();
        chk("t4_hold_instr2", if_id_instr, 32'h0030_8193);
        chk("t4_hold_req2", {31'h0, imem_req}, 32'h0);
        exp_ifid_q.push_back({32'hC, 32'h00A0_0113});
        stall = 1'b0;
        tick();
        chk("t4_req", {31'h0, imem_req}, 32'h1);
        chk("t4_addr", imem_addr, 32'h10);
        chk("t4_valid", {31'h0, if_id_valid}, 32'h1);

        // 5: flush wins over stall
        flush = 1'b1; stall = 1'b1;
        tick();
        flush = 1'b0; stall = 1'b0;
        chk("t5_valid", {31'h0, if_id_valid}, 32'h0);
        chk("t5_instr", if_id_instr, 32'h0000_0013);
        chk("t5_pc", if_id_pc, 32'hC);
        chk("t5_addr", imem_addr, 32'h10);

        // 6: PC wrap, then reset while waiting with a late response
        pc_jump = 1'b1; pc_jump_addr = 32'hFFFF_FFFC; flush = 1'b1;
        tick();
        pc_jump = 1'b0; flush = 1'b0;
        fetch(32'hFFFF_FFFC, 32'h0000_0033, 0);
        exp_addr_q.push_back(32'h0);
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        rst = 1'b1;
        tick();
        chk("t6_rst_req", {31'h0, imem_req}, 32'h0);
        chk("t6_rst_pc", if_id_pc, 32'h0);
        chk("t6_rst_instr", if_id_instr, 32'h0000_0013);
        rst = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hBADB_AD00;
        tick();
        tick();
        imem_rvalid = 1'b0;
        chk("t6_late_valid", {31'h0, if_id_valid}, 32'h0);
        chk("t6_req", {31'h0, imem_req}, 32'h1);
        chk("t6_addr", imem_addr, 32'h0);
        fetch(32'h0, 32'h0070_0393, 0);

        repeat (3) tick();
        chk("addr_q_drained", exp_addr_q.size(), 32'h0);
        chk("ifid_q_drained", exp_ifid_q.size(), 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
